// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, synchronous ROM addressing and a one-entry skid
// buffer so the F/D latch never loses or repeats an instruction across stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          IMEM_ADDR_W = 12,
  parameter logic [31:0] NOP         = 32'h00000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_q,
  output logic [31:0]            fd_ir,
  output logic [31:0]            fd_pc,
  output logic                   fd_enable,
  output logic                   fd_valid
);

  typedef enum logic [1:0] {EMPTY, RUN, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q, req_pc_q, hold_ir_q;

  assign imem_addr = pc_q[IMEM_ADDR_W-1:0];
  assign fd_enable = ~stall | redirect_valid;

  // A redirect squashes whatever the mux would present this cycle.
  always_comb begin
    fd_ir    = NOP;
    fd_pc    = 32'd0;
    fd_valid = 1'b0;
    if (!redirect_valid) begin
      case (state_q)
        RUN: begin
          fd_ir    = imem_q;
          fd_pc    = req_pc_q + 32'd1;
          fd_valid = 1'b1;
        end
        HOLD: begin
          fd_ir    = hold_ir_q;
          fd_pc    = req_pc_q + 32'd1;
          fd_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= 32'd0;
      hold_ir_q <= NOP;
      state_q   <= EMPTY;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      state_q <= EMPTY;
    end else if (stall) begin
      // ROM output moves on to mem[pc] next cycle, so capture it now.
      if (state_q == RUN) begin
        hold_ir_q <= imem_q;
        state_q   <= HOLD;
      end
    end else begin
      req_pc_q <= pc_q;
      pc_q     <= pc_q + 32'd1;
      state_q  <= RUN;
    end
  end

endmodule
